// File: rtl/noc_pkg.sv
// Shared NoC definitions: VC indices, default flit width and the flit type
// used by the network interface, link mux and router.
package noc_pkg;

  localparam int FLIT_WIDTH_DEFAULT = 128;

  localparam int VC_REQUEST   = 0;
  localparam int VC_RESPONSE  = 1;
  localparam int VC_COHERENCE = 2;

  typedef logic [FLIT_WIDTH_DEFAULT-1:0] flit_t;

  function automatic int next_vc(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO with occupancy count; DEPTH must be a power of two so
// the read/write pointers wrap naturally.
module noc_flit_fifo
  import noc_pkg::*;
#(
  parameter int WIDTH = FLIT_WIDTH_DEFAULT,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/noc_vc_link_mux.sv
// Per-VC buffered, credit-gated round-robin mux onto the router injection link.
// Define NOC_VC_RESP_PRIORITY_EN to give the response VC absolute priority.
module noc_vc_link_mux
  import noc_pkg::*;
#(
  parameter int VC_COUNT     = 3,
  parameter int FLIT_WIDTH   = FLIT_WIDTH_DEFAULT,
  parameter int FIFO_DEPTH   = 4,
  parameter int CREDIT_COUNT = 4,
  parameter int VC_W         = $clog2(VC_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [VC_COUNT-1:0][FLIT_WIDTH-1:0]  ni_flit_in,
  input  logic [VC_COUNT-1:0]                  ni_valid_in,
  output logic [VC_COUNT-1:0]                  ni_ready_out,
  output logic [FLIT_WIDTH-1:0]                link_flit_out,
  output logic [VC_W-1:0]                      link_vc_out,
  output logic                                 link_valid_out,
  input  logic [VC_COUNT-1:0]                  link_credit_in,
  output logic                                 credit_err_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W = $clog2(CREDIT_COUNT + 1);

  logic [CNT_W-1:0]      fifo_count [VC_COUNT];
  logic [FLIT_WIDTH-1:0] fifo_rd    [VC_COUNT];
  logic [CRD_W-1:0]      credit_q   [VC_COUNT];
  logic [VC_COUNT-1:0]   fifo_full;
  logic [VC_COUNT-1:0]   push;
  logic [VC_COUNT-1:0]   eligible;
  logic [VC_COUNT-1:0]   grant_vec;
  logic [VC_COUNT-1:0]   credit_ovf;
  logic [VC_W-1:0]       rr_ptr;
  logic [VC_W-1:0]       rr_next;
  logic [VC_W-1:0]       grant_idx;
  logic                  grant_any;
  logic                  rr_adv;
  logic [FLIT_WIDTH-1:0] grant_flit;

  generate
    for (genvar v = 0; v < VC_COUNT; v++) begin : g_vc
      assign ni_ready_out[v] = !fifo_full[v];
      assign push[v]         = ni_valid_in[v] && !fifo_full[v];
      assign eligible[v]     = (fifo_count[v] != '0) && (credit_q[v] != '0);
      assign credit_ovf[v]   = link_credit_in[v] && !grant_vec[v] &&
                               (credit_q[v] == CRD_W'(CREDIT_COUNT));

      noc_flit_fifo #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
      ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push[v]),
        .wr_data (ni_flit_in[v]),
        .pop     (grant_vec[v]),
        .rd_data (fifo_rd[v]),
        .count   (fifo_count[v]),
        .full    (fifo_full[v])
      );
    end
  endgenerate

  always_comb begin
    int idx;
    idx        = 0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_vec  = '0;
    grant_flit = '0;
    rr_adv     = 1'b0;
    rr_next    = '0;

    for (int i = 0; i < VC_COUNT; i++) begin
      idx = (int'(rr_ptr) + i) % VC_COUNT;
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = VC_W'(idx);
      end
    end

`ifdef NOC_VC_RESP_PRIORITY_EN
    // Response drain must never wait behind requests; the pointer is left
    // alone so the other VCs keep their round-robin position.
    if (eligible[VC_RESPONSE]) begin
      grant_any = 1'b1;
      grant_idx = VC_W'(VC_RESPONSE);
    end
    rr_adv = grant_any && (grant_idx != VC_W'(VC_RESPONSE));
`else
    rr_adv = grant_any;
`endif

    rr_next = VC_W'(next_vc(int'(grant_idx), VC_COUNT));

    for (int v = 0; v < VC_COUNT; v++) begin
      grant_vec[v] = grant_any && (grant_idx == VC_W'(v));
      if (grant_vec[v]) grant_flit = fifo_rd[v];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < VC_COUNT; v++) credit_q[v] <= CRD_W'(CREDIT_COUNT);
    end else begin
      for (int v = 0; v < VC_COUNT; v++) begin
        case ({grant_vec[v], link_credit_in[v]})
          2'b10:   credit_q[v] <= credit_q[v] - 1'b1;
          2'b01:   if (credit_q[v] != CRD_W'(CREDIT_COUNT)) credit_q[v] <= credit_q[v] + 1'b1;
          default: credit_q[v] <= credit_q[v];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr         <= '0;
      link_flit_out  <= '0;
      link_vc_out    <= '0;
      link_valid_out <= 1'b0;
      credit_err_out <= 1'b0;
    end else begin
      if (rr_adv) rr_ptr <= rr_next;
      if (grant_any) begin
        link_flit_out  <= grant_flit;
        link_vc_out    <= grant_idx;
        link_valid_out <= 1'b1;
      end else begin
        link_valid_out <= 1'b0;
      end
      if (|credit_ovf) credit_err_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_vc_link_mux.sv
// Directed scoreboard bench for noc_vc_link_mux (expected link flits queued at drive time).
module tb_noc_vc_link_mux;

  localparam int VC_COUNT = 3;
  localparam int FW       = 128;
  localparam int VC_W     = 2;

  logic                         clk = 1'b0;
  logic                         reset;
  logic [VC_COUNT-1:0][FW-1:0]  ni_flit_in;
  logic [VC_COUNT-1:0]          ni_valid_in;
  logic [VC_COUNT-1:0]          ni_ready_out;
  logic [FW-1:0]                link_flit_out;
  logic [VC_W-1:0]              link_vc_out;
  logic                         link_valid_out;
  logic [VC_COUNT-1:0]          link_credit_in;
  logic                         credit_err_out;

  always #5 clk = ~clk;

  noc_vc_link_mux #(
    .VC_COUNT     (VC_COUNT),
    .FLIT_WIDTH   (FW),
    .FIFO_DEPTH   (4),
    .CREDIT_COUNT (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ni_flit_in     (ni_flit_in),
    .ni_valid_in    (ni_valid_in),
    .ni_ready_out   (ni_ready_out),
    .link_flit_out  (link_flit_out),
    .link_vc_out    (link_vc_out),
    .link_valid_out (link_valid_out),
    .link_credit_in (link_credit_in),
    .credit_err_out (credit_err_out)
  );

  typedef struct {
    logic [VC_W-1:0] vc;
    logic [FW-1:0]   flit;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [FW+1:0] obs, input logic [FW+1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_flit(input int v, input logic [FW-1:0] d);
    exp_t e;
    e.vc   = VC_W'(v);
    e.flit = d;
    exp_q.push_back(e);
  endtask

  task automatic check_link();
    exp_t e;
    if (link_valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("link_unexpected", link_valid_out, 0);
      end else begin
        e = exp_q.pop_front();
        chk("link_vc", link_vc_out, e.vc);
        chk("link_flit", link_flit_out, e.flit);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_link();
  endtask

  task automatic push_flit(input int v, input logic [FW-1:0] d);
    int g;
    g = 0;
    while (!ni_ready_out[v] && g < 50) begin
      tick();
      g++;
    end
    if (g >= 50) chk("push_timeout", ni_ready_out[v], 1);
    ni_valid_in[v] = 1'b1;
    ni_flit_in[v]  = d;
    tick();
    ni_valid_in[v] = 1'b0;
  endtask

  task automatic credit_pulse(input int v, input int n);
    for (int k = 0; k < n; k++) begin
      link_credit_in[v] = 1'b1;
      tick();
    end
    link_credit_in[v] = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 40) begin
      tick();
      g++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    reset          = 1'b1;
    ni_flit_in     = '0;
    ni_valid_in    = '0;
    link_credit_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", link_valid_out, 0);
    chk("reset_flit", link_flit_out, 0);
    chk("reset_vc", link_vc_out, 0);
    chk("reset_err", credit_err_out, 0);
    chk("reset_ready", ni_ready_out, 3'b111);
    reset = 1'b0;
    tick();

    // single VC latency
    expect_flit(2, 128'hA5);
    ni_valid_in[2] = 1'b1;
    ni_flit_in[2]  = 128'hA5;
    tick();
    chk("lat_early", link_valid_out, 0);
    ni_valid_in[2] = 1'b0;
    tick();
    chk("lat_valid", link_valid_out, 1);
    chk("lat_queue", exp_q.size(), 0);

    // round-robin over all three VCs
`ifdef NOC_VC_RESP_PRIORITY_EN
    expect_flit(1, 128'h110); expect_flit(1, 128'h111);
    expect_flit(0, 128'h100); expect_flit(2, 128'h120);
    expect_flit(0, 128'h101); expect_flit(2, 128'h121);
`else
    for (int r = 0; r < 2; r++)
      for (int v = 0; v < VC_COUNT; v++) expect_flit(v, FW'(128'h100 + 16 * v + r));
`endif
    for (int r = 0; r < 2; r++) begin
      ni_valid_in = 3'b111;
      for (int v = 0; v < VC_COUNT; v++) ni_flit_in[v] = FW'(128'h100 + 16 * v + r);
      tick();
    end
    ni_valid_in = '0;
    drain("rr_drain");
    chk("rr_ptr_wrap", dut.rr_ptr, 0);
    credit_pulse(0, 2);
    credit_pulse(1, 2);
    credit_pulse(2, 3);

    // credit exhaustion on VC0
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_flit(0, FW'(128'h200 + i));
      push_flit(0, FW'(128'h200 + i));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("exh_hold", link_valid_out, 0);
    end
    chk("exh_credit", dut.credit_q[0], 0);
    chk("exh_fifo", dut.fifo_count[0], 1);
    expect_flit(0, 128'h204);
    link_credit_in[0] = 1'b1;
    tick();
    chk("exh_wait", link_valid_out, 0);
    link_credit_in[0] = 1'b0;
    tick();
    chk("exh_release", link_valid_out, 1);
    tick();
    chk("exh_single", link_valid_out, 0);
    chk("exh_queue", exp_q.size(), 0);

    // reset mid-stream with two flits stuck on VC0 (no credits)
    push_flit(0, 128'h300);
    push_flit(0, 128'h301);
    chk("rst_pre_count", dut.fifo_count[0], 2);
    reset = 1'b1;
    #1;
    chk("rst_valid", link_valid_out, 0);
    chk("rst_ready", ni_ready_out, 3'b111);
    chk("rst_flit", link_flit_out, 0);
    chk("rst_fifo", dut.fifo_count[0], 0);
    chk("rst_credit", dut.credit_q[0], 4);
    tick();
    tick();
    reset = 1'b0;

    // credit overflow at reset state
    link_credit_in[1] = 1'b1;
    tick();
    link_credit_in[1] = 1'b0;
    chk("ovf_err", credit_err_out, 1);
    chk("ovf_credit", dut.credit_q[1], 4);
    repeat (3) tick();
    chk("ovf_sticky", credit_err_out, 1);
    chk("ovf_credit_hold", dut.credit_q[1], 4);

    // after reset: use up credits, then four flits fill the empty FIFO
    for (int i = 0; i < 4; i++) begin
      expect_flit(0, FW'(128'h400 + i));
      push_flit(0, FW'(128'h400 + i));
    end
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      if (!ni_ready_out[0]) break;
      expect_flit(0, FW'(128'h500 + acc));
      ni_valid_in[0] = 1'b1;
      ni_flit_in[0]  = FW'(128'h500 + acc);
      tick();
      acc++;
    end
    ni_valid_in[0] = 1'b0;
    chk("rst_accept4", acc, 4);
    chk("rst_ready_low", ni_ready_out[0], 0);
    credit_pulse(0, 4);
    drain("rst_drain");
    credit_pulse(0, 4);
    chk("rst_credit_back", dut.credit_q[0], 4);

    // simultaneous grant+credit and push+pop on VC0
    expect_flit(0, 128'h600);
    expect_flit(0, 128'h601);
    ni_valid_in[0] = 1'b1;
    ni_flit_in[0]  = 128'h600;
    tick();
    chk("sim_count_pre", dut.fifo_count[0], 1);
    chk("sim_credit_pre", dut.credit_q[0], 4);
    ni_flit_in[0]     = 128'h601;
    link_credit_in[0] = 1'b1;
    tick();
    ni_valid_in[0]    = 1'b0;
    link_credit_in[0] = 1'b0;
    chk("sim_count", dut.fifo_count[0], 1);
    chk("sim_credit", dut.credit_q[0], 4);
    drain("sim_drain");
    credit_pulse(0, 1);

    // VC0 vs VC1 contention from rr_ptr = 0
    expect_flit(2, 128'h700);
    push_flit(2, 128'h700);
    drain("prio_setup");
    chk("prio_rr0", dut.rr_ptr, 0);
`ifdef NOC_VC_RESP_PRIORITY_EN
    expect_flit(1, 128'h801);
    expect_flit(0, 128'h800);
`else
    expect_flit(0, 128'h800);
    expect_flit(1, 128'h801);
`endif
    ni_valid_in   = 3'b011;
    ni_flit_in[0] = 128'h800;
    ni_flit_in[1] = 128'h801;
    tick();
    ni_valid_in = '0;
    drain("prio_drain");
`ifdef NOC_VC_RESP_PRIORITY_EN
    chk("prio_rr_end", dut.rr_ptr, 1);
`else
    chk("prio_rr_end", dut.rr_ptr, 2);
`endif
    chk("final_err_sticky", credit_err_out, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
